// File: rtl/sine_sweep_ctrl.sv
//------------------------------------------------------------------------------
// sine_sweep_ctrl -- FCW sweep sequencer (up / triangle / continuous) for the
// sine DDS. Optional SWEEP_SYNC_OUT_EN adds a sweep_sync strobe. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sine_sweep_ctrl #(
  parameter int PHASE_W = 16,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  input  logic [2:0]         cfg_addr,
  input  logic [7:0]         cfg_data,
  output logic               cfg_ready,
  output logic [PHASE_W-1:0] fcw,
  output logic               fcw_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
`ifdef SWEEP_SYNC_OUT_EN
  ,
  output logic               sweep_sync
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t             r_state;
  logic [PHASE_W-1:0] r_fstart;
  logic [PHASE_W-1:0] r_fstop;
  logic [PHASE_W-1:0] r_fcw;
  logic [7:0]         r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic [1:0]         r_mode;
  logic               r_fcw_valid;
  logic               r_done;

  logic [PHASE_W-1:0] w_step;
  logic [PHASE_W-1:0] w_fstop_eff;
  logic [PHASE_W:0]   w_up_sum;
  logic [PHASE_W:0]   w_dn_diff;
  logic [PHASE_W-1:0] w_up_next;
  logic [PHASE_W-1:0] w_dn_next;
  logic               w_expire;
  logic               w_up_end;
  logic               w_dn_end;
  logic               w_start_go;
  logic               w_cfg_ready;
  logic               w_cfg_we;

  assign w_step      = {{(PHASE_W-8){1'b0}}, (r_step == 8'd0) ? 8'd1 : r_step};
  assign w_fstop_eff = (r_fstop <= r_fstart) ? r_fstart : r_fstop;

  // Extra MSB keeps the sum/difference honest near the ends of the code range.
  assign w_up_sum  = {1'b0, r_fcw} + {1'b0, w_step};
  assign w_dn_diff = {1'b0, r_fcw} - {1'b0, w_step};
  assign w_up_next = (w_up_sum > {1'b0, w_fstop_eff}) ? w_fstop_eff : w_up_sum[PHASE_W-1:0];
  assign w_dn_next = (w_dn_diff[PHASE_W] || (w_dn_diff[PHASE_W-1:0] < r_fstart))
                     ? r_fstart : w_dn_diff[PHASE_W-1:0];

  assign w_expire    = (r_cnt == r_dwell);
  assign w_up_end    = !(r_fcw < w_fstop_eff);
  assign w_dn_end    = !(r_fcw > r_fstart);
  assign w_start_go  = (r_state == S_IDLE) && start && ena && !stop;
  assign w_cfg_ready = rst_n && (r_state == S_IDLE);
  assign w_cfg_we    = cfg_valid && w_cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_fstart    <= '0;
      r_fstop     <= '0;
      r_fcw       <= '0;
      r_step      <= 8'd1;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_mode      <= 2'd0;
      r_fcw_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_fcw_valid <= 1'b0;
      r_done      <= 1'b0;

      if (w_cfg_we) begin
        case (cfg_addr)
          3'd0: r_fstart[7:0]         <= cfg_data;
          3'd1: r_fstart[PHASE_W-1:8] <= cfg_data[PHASE_W-9:0];
          3'd2: r_fstop[7:0]          <= cfg_data;
          3'd3: r_fstop[PHASE_W-1:8]  <= cfg_data[PHASE_W-9:0];
          3'd4: r_step                <= cfg_data;
          3'd5: r_dwell               <= cfg_data[DWELL_W-1:0];
          3'd6: r_mode                <= cfg_data[1:0];
          default: ;
        endcase
      end

      if (stop) begin
        r_state <= S_IDLE;
      end else if (ena) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state     <= S_UP;
              r_fcw       <= r_fstart;
              r_fcw_valid <= 1'b1;
              r_cnt       <= '0;
            end
          end
          S_UP: begin
            if (!w_expire) begin
              r_cnt <= r_cnt + DWELL_W'(1);
            end else begin
              r_cnt <= '0;
              if (!w_up_end) begin
                r_fcw       <= w_up_next;
                r_fcw_valid <= 1'b1;
              end else if (r_mode[0]) begin
                r_state     <= S_DOWN;
                r_fcw       <= w_dn_next;
                r_fcw_valid <= 1'b1;
              end else if (r_mode[1]) begin
                r_fcw       <= r_fstart;
                r_fcw_valid <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          S_DOWN: begin
            if (!w_expire) begin
              r_cnt <= r_cnt + DWELL_W'(1);
            end else begin
              r_cnt <= '0;
              if (!w_dn_end) begin
                r_fcw       <= w_dn_next;
                r_fcw_valid <= 1'b1;
              end else if (r_mode[1]) begin
                r_state     <= S_UP;
                r_fcw       <= w_up_next;
                r_fcw_valid <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SWEEP_SYNC_OUT_EN
  logic w_sync_set;
  logic r_sync;

  // Mirrors the FSM branches that begin a fresh UP pass.
  assign w_sync_set = w_start_go ||
                      (ena && !stop && w_expire &&
                       (((r_state == S_UP) && w_up_end && !r_mode[0] && r_mode[1]) ||
                        ((r_state == S_DOWN) && w_dn_end && r_mode[1])));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= w_sync_set;
    end
  end

  assign sweep_sync = r_sync;
`endif

  assign cfg_ready = w_cfg_ready;
  assign fcw       = r_fcw;
  assign fcw_valid = r_fcw_valid;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sine_sweep_ctrl.sv
//------------------------------------------------------------------------------
// tb_sine_sweep_ctrl -- scoreboard bench: expected FCW writes are queued at
// stimulus time and matched against every fcw_valid strobe.
//------------------------------------------------------------------------------
`default_nettype none

module tb_sine_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, stop, cfg_valid;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_ready, fcw_valid, busy, done;
  logic [15:0] fcw;
  logic [1:0]  state;
`ifdef SWEEP_SYNC_OUT_EN
  logic        sweep_sync;
`endif

  sine_sweep_ctrl #(.PHASE_W(16), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .fcw       (fcw),
    .fcw_valid (fcw_valid),
    .busy      (busy),
    .done      (done),
    .state     (state)
`ifdef SWEEP_SYNC_OUT_EN
    ,
    .sweep_sync(sweep_sync)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    int          gap;
    bit          sync;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_strobe_cyc = 0;
  int   last_done_cyc   = 0;
  int   n_done  = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] v, input int gap, input bit sync);
    exp_t e;
    e.v = v; e.gap = gap; e.sync = sync;
    q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: every strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (fcw_valid) begin
        if (q.size() == 0) begin
          check("fcw_queue_nonempty", q.size(), 1);
        end else begin
          e = q.pop_front();
          check("fcw", fcw, e.v);
          if (e.gap > 0) check("fcw_gap", cyc - last_strobe_cyc, e.gap);
`ifdef SWEEP_SYNC_OUT_EN
          check("sweep_sync", sweep_sync, e.sync);
`endif
        end
        last_strobe_cyc = cyc;
      end
`ifdef SWEEP_SYNC_OUT_EN
      else if (sweep_sync) begin
        check("sync_without_valid", sweep_sync, 0);
      end
`endif
      if (done) begin
        n_done++;
        last_done_cyc = cyc;
        check("busy_at_done", busy, 0);
        check("done_width", prev_done, 0);
      end
    end
    prev_done = done;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [7:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic prog(input logic [15:0] fs, input logic [15:0] fe, input logic [7:0] st,
                      input logic [7:0] dw, input logic [7:0] md);
    cfg_wr(3'd0, fs[7:0]);  cfg_wr(3'd1, fs[15:8]);
    cfg_wr(3'd2, fe[7:0]);  cfg_wr(3'd3, fe[15:8]);
    cfg_wr(3'd4, st);       cfg_wr(3'd5, dw);
    cfg_wr(3'd6, md);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (state != 2'd0 && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_timeout"}, (k >= budget), 0);
    @(negedge clk);
    #1;
    check({tag, "_queue_drained"}, q.size(), 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; ena = 1'b1; start = 1'b1; stop = 1'b0;
    cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;

    // Reset with start held high
    tick(2);
    check("rst_fcw", fcw, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_fcw_valid", fcw_valid, 0);
    rst_n = 1'b1; start = 1'b0;
    tick(1);
    check("cfg_ready_idle", cfg_ready, 1);
    check("idle_state", state, 0);

    // Single up sweep, dwell 2
    prog(16'h0100, 16'h0140, 8'h10, 8'd2, 8'd0);
    push(16'h0100, 0, 1); push(16'h0110, 3, 0); push(16'h0120, 3, 0);
    push(16'h0130, 3, 0); push(16'h0140, 3, 0);
    d0 = n_done;
    pulse_start();
    check("up_busy", busy, 1);
    check("up_state", state, 1);
    wait_idle("up", 100);
    check("up_done_count", n_done, d0 + 1);
    check("up_done_gap", last_done_cyc - last_strobe_cyc, 3);
    check("up_final_fcw", fcw, 16'h0140);

    // Bidirectional triangle, dwell 0
    prog(16'h0010, 16'h0030, 8'h10, 8'd0, 8'd1);
    push(16'h0010, 0, 1); push(16'h0020, 1, 0); push(16'h0030, 1, 0);
    push(16'h0020, 1, 0); push(16'h0010, 1, 0);
    d0 = n_done;
    pulse_start();
    wait_idle("bidir", 50);
    check("bidir_done_count", n_done, d0 + 1);
    check("bidir_done_gap", last_done_cyc - last_strobe_cyc, 1);

    // Overflow clamp at top of range
    prog(16'hFFF0, 16'hFFFF, 8'h20, 8'd0, 8'd0);
    push(16'hFFF0, 0, 1); push(16'hFFFF, 1, 0);
    d0 = n_done;
    pulse_start();
    wait_idle("clamp", 50);
    check("clamp_done_count", n_done, d0 + 1);

    // fstop below fstart: single value held dwell+1
    prog(16'h0080, 16'h0050, 8'h01, 8'd3, 8'd0);
    push(16'h0080, 0, 1);
    d0 = n_done;
    pulse_start();
    wait_idle("degen", 50);
    check("degen_done_count", n_done, d0 + 1);
    check("degen_done_gap", last_done_cyc - last_strobe_cyc, 4);

    // step 0 behaves as step 1
    prog(16'h0005, 16'h0007, 8'h00, 8'd0, 8'd0);
    push(16'h0005, 0, 1); push(16'h0006, 1, 0); push(16'h0007, 1, 0);
    d0 = n_done;
    pulse_start();
    wait_idle("step0", 50);
    check("step0_done_count", n_done, d0 + 1);

    // Continuous up, stopped while fcw=1 on the second pass
    prog(16'h0000, 16'h0002, 8'h01, 8'd0, 8'd2);
    push(16'h0000, 0, 1); push(16'h0001, 1, 0); push(16'h0002, 1, 0);
    push(16'h0000, 1, 1); push(16'h0001, 1, 0);
    d0 = n_done;
    pulse_start();
    tick(4);
    check("cont_fcw_before_stop", fcw, 16'h0001);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_state", state, 0);
    check("stop_fcw_hold", fcw, 16'h0001);
    check("stop_fcw_valid", fcw_valid, 0);
    check("stop_done", done, 0);
    tick(2);
    check("stop_no_done", n_done, d0);
    check("stop_queue_drained", q.size(), 0);

    // Interlocks: dropped write while busy, ena freeze mid-hold
    prog(16'h0100, 16'h0140, 8'h10, 8'd2, 8'd0);
    push(16'h0100, 0, 1); push(16'h0110, 3, 0); push(16'h0120, 8, 0);
    push(16'h0130, 3, 0); push(16'h0140, 3, 0);
    d0 = n_done;
    pulse_start();
    check("busy_cfg_ready", cfg_ready, 0);
    cfg_wr(3'd4, 8'h40);
    tick(2);
    check("pre_freeze_fcw", fcw, 16'h0110);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("freeze_fcw", fcw, 16'h0110);
      check("freeze_valid", fcw_valid, 0);
    end
    ena = 1'b1;
    wait_idle("freeze", 100);
    check("freeze_done_count", n_done, d0 + 1);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_state", state, 0);
    check("startstop_busy", busy, 0);

    // Reset mid-sweep also clears config
    push(16'h0100, 0, 1);
    pulse_start();
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_fcw", fcw, 0);
    check("midrst_state", state, 0);
    rst_n = 1'b1;
    push(16'h0000, 0, 1);
    d0 = n_done;
    pulse_start();
    wait_idle("postrst", 50);
    check("postrst_done_count", n_done, d0 + 1);
    check("postrst_done_gap", last_done_cyc - last_strobe_cyc, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
